alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Issue and writeback stage that sits directly upstream of the ALU. It accepts one operation per request over a valid/ready handshake and drives the ALU operand, opcode and enable lines. It samples the ALU's held r/s result and returns it over a second valid/ready handshake. It can repeat an operation up to 2^REP_W-1 extra times, feeding each result back into x; this supports multi-bit shifts and rotates built from single-step ops.

Parameters:
REP_W, 3, width of the repeat count; the maximum number of extra iterations is 2^REP_W-1.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_x  in  8  operand x
req_y  in  8  operand y
req_m  in  8  operand m, passed through unchanged
req_op  in  math  operation, type math from instr_pack
req_rs  in  1  destination ALU result register: 0 = r, 1 = s
req_rep  in  REP_W  number of extra iterations; 0 = single execution
alu_x  out  8  to ALU x
alu_y  out  8  to ALU y
alu_m  out  8  to ALU m
alu_math  out  math  to ALU math_op
alu_en  out  1  to ALU alu_en
alu_rs  out  1  to ALU alu_rs
alu_r  in  8  from ALU r_out
alu_s  in  8  from ALU s_out
res_valid  out  1  result present
res_ready  in  1  consumer accepts the result
res_data  out  8  result
res_rs  out  1  destination register of the result
res_zero  out  1  res_data == 0
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- While reset is high and on the cycle after it:
  - state is IDLE.
  - alu_en, res_valid, busy and res_rs are 0.
  - res_data, alu_x, alu_y and alu_m are 0x00.
  - alu_math is amp (enum value 0).
  - req_ready is 0 while reset is high, and 1 from the first cycle after reset.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch x_q, y_q, m_q, op_q, rs_q and rep_q from the req_* inputs, then go to DRIVE.
- DRIVE:
  - alu_en = 1 for exactly this one cycle.
  - alu_x/y/m/math/rs are driven from x_q, y_q, m_q, op_q, rs_q.
  - Next state: SAMPLE, unconditionally.
- SAMPLE:
  - alu_en = 0. Operand and opcode outputs hold their DRIVE values, so the ALU latch holds its result.
  - Sampled value v = rs_q ? alu_s : alu_r.
  - If rep_q != 0: x_q <= v, rep_q <= rep_q - 1, go to DRIVE. y_q, m_q and op_q are unchanged.
  - Otherwise: res_data <= v, res_rs <= rs_q, go to DONE.
- DONE:
  - res_valid = 1. res_data, res_rs and res_zero are stable until the handshake.
  - On res_ready: go to IDLE. req_ready rises the following cycle; there is no same-cycle bypass.
- Outputs in IDLE and DONE: alu_en = 0 and the ALU-side outputs hold their last values. The ALU latches are therefore never disturbed outside DRIVE.
- Latency (request accepted at edge k):
  - res_valid is first high after edge k+2+2*rep.
  - alu_en pulses rep+1 times.
  - Throughput is at most one operation per 4+2*rep cycles.
- Repeat rules:
  - rep applies to every op, with feedback into x only.
  - For ops that ignore x, repetition is legal but redundant.
  - rep_q decrements to 0 and never wraps.
- Boundaries:
  - req_valid outside IDLE is ignored, and the request is not consumed.
  - res_ready outside DONE has no effect.
  - Reset in any state aborts the operation: no res_valid is produced and the partial result is discarded. In-flight ALU latch contents are don't-care.
- Widths: all data is 8-bit with no carry out. Arithmetic wrap-around is the ALU's responsibility; this block passes values unchanged.

Test Plan:
1. Reset, then add with x=0x05, y=0x03, rs=0, rep=0 -> one alu_en pulse; res_valid 3 cycles after accept; res_data=0x08, res_rs=0, res_zero=0; alu_r=0x08.
2. sub with x=0x10, y=0x10, rs=1 -> res_data=0x00, res_zero=1, res_rs=1; alu_s=0x00 and alu_r unchanged.
3. rsc with x=0x80, y=0x00, rep=3 -> 4 alu_en pulses with alu_x sequence 0x80, 0x40, 0x20, 0x10; res_data=0x08; res_valid 9 cycles after accept.
4. rol with x=0x81, y=0x01, rep=1 -> res_data=0x06 (0x81 -> 0x03 -> 0x06); y stays 0x01 across iterations.
5. Backpressure: hold res_ready=0 for 5 cycles while presenting a second request -> res_data is stable, req_ready=0 and the second request is not taken. Release res_ready -> IDLE the next cycle, then the second request is accepted.
6. Assert reset in SAMPLE during a rep=2 operation -> IDLE the next cycle; busy=0, res_valid stays 0, no further alu_en pulses; a following add of 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback sequencer in front of the ALU with repeat-and-feedback support

package instr_pack;
    typedef enum logic [2:0] {
        amp = 3'd0,
        add = 3'd1,
        sub = 3'd2,
        lsc = 3'd3,
        rsc = 3'd4,
        rol = 3'd5,
        ror = 3'd6,
        mov = 3'd7
    } math;
endpackage

module alu_sequencer #(
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_x,
    input  logic [7:0]       req_y,
    input  logic [7:0]       req_m,
    input  instr_pack::math  req_op,
    input  logic             req_rs,
    input  logic [REP_W-1:0] req_rep,
    output logic [7:0]       alu_x,
    output logic [7:0]       alu_y,
    output logic [7:0]       alu_m,
    output instr_pack::math  alu_math,
    output logic             alu_en,
    output logic             alu_rs,
    input  logic [7:0]       alu_r,
    input  logic [7:0]       alu_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic             res_rs,
    output logic             res_zero,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [7:0]        m_q;
    instr_pack::math   op_q;
    logic              rs_q;
    logic [REP_W-1:0]  rep_q;
    logic [7:0]        res_data_q;
    logic              res_rs_q;
    logic [7:0]        sampled;

    // The ALU holds its result in r or s; pick the one this op targets.
    assign sampled = rs_q ? alu_s : alu_r;

    // Operands are registered and held between DRIVE pulses so the ALU latches stay undisturbed;
    // everything is forced to its idle value while reset is asserted.
    assign alu_x    = reset ? 8'h00 : x_q;
    assign alu_y    = reset ? 8'h00 : y_q;
    assign alu_m    = reset ? 8'h00 : m_q;
    assign alu_math = reset ? instr_pack::amp : op_q;
    assign alu_rs   = reset ? 1'b0 : rs_q;
    assign res_data = reset ? 8'h00 : res_data_q;
    assign res_rs   = reset ? 1'b0 : res_rs_q;
    assign res_zero = (res_data == 8'h00);
    assign busy     = !reset && (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/enable outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        alu_en     = 1'b0;
        res_valid  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    alu_en     = 1'b1;
                    state_next = SAMPLE;
                end
                SAMPLE: begin
                    state_next = (rep_q != '0) ? DRIVE : DONE;
                end
                DONE: begin
                    res_valid = 1'b1;
                    if (res_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, feedback of each intermediate result into x, and final result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= 8'h00;
            y_q        <= 8'h00;
            m_q        <= 8'h00;
            op_q       <= instr_pack::amp;
            rs_q       <= 1'b0;
            rep_q      <= '0;
            res_data_q <= 8'h00;
            res_rs_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        x_q   <= req_x;
                        y_q   <= req_y;
                        m_q   <= req_m;
                        op_q  <= req_op;
                        rs_q  <= req_rs;
                        rep_q <= req_rep;
                    end
                end
                SAMPLE: begin
                    if (rep_q != '0) begin
                        x_q   <= sampled;
                        rep_q <= rep_q - 1'b1;
                    end else begin
                        res_data_q <= sampled;
                        res_rs_q   <= rs_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a stand-in ALU and an operation-level model

module tb_alu_sequencer;
    import instr_pack::*;

    localparam int REP_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_x;
    logic [7:0]       req_y;
    logic [7:0]       req_m;
    math              req_op;
    logic             req_rs;
    logic [REP_W-1:0] req_rep;
    logic [7:0]       alu_x;
    logic [7:0]       alu_y;
    logic [7:0]       alu_m;
    math              alu_math;
    logic             alu_en;
    logic             alu_rs;
    logic [7:0]       alu_r = 8'h00;
    logic [7:0]       alu_s = 8'h00;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic             res_rs;
    logic             res_zero;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulses = 0;

    alu_sequencer #(.REP_W(REP_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_m(req_m), .req_op(req_op),
        .req_rs(req_rs), .req_rep(req_rep),
        .alu_x(alu_x), .alu_y(alu_y), .alu_m(alu_m), .alu_math(alu_math),
        .alu_en(alu_en), .alu_rs(alu_rs), .alu_r(alu_r), .alu_s(alu_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rs(res_rs), .res_zero(res_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_f(math op, logic [7:0] x, logic [7:0] y);
        case (op)
            amp:     return x & y;
            add:     return x + y;
            sub:     return x - y;
            lsc:     return {x[6:0], y[0]};
            rsc:     return {y[0], x[7:1]};
            rol:     return {x[6:0], x[7]};
            ror:     return {x[0], x[7:1]};
            mov:     return y;
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in ALU: result latched into r or s only on an enable pulse.
    always @(posedge clk) begin
        if (alu_en) begin
            if (alu_rs) alu_s <= alu_f(alu_math, alu_x, alu_y);
            else        alu_r <= alu_f(alu_math, alu_x, alu_y);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operation-level model: one op in flight at most.
    logic       inflight   = 1'b0;
    logic       seen_valid = 1'b0;
    logic [7:0] exp_data;
    logic       exp_rs;
    int         exp_due;
    logic [7:0] cur_y;
    logic [7:0] cur_m;
    math        cur_op;
    logic       cur_rs;
    logic [7:0] exp_x[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_req_ready", req_ready, 0);
            chk("reset_outputs", {alu_en, res_valid, busy, res_rs, res_data, alu_x, alu_y, alu_m},
                0);
            chk("reset_math", alu_math, amp);
            exp_x.delete();
            inflight   = 1'b0;
            seen_valid = 1'b0;
        end else begin
            chk("busy", busy, inflight);
            chk("req_ready", req_ready, !inflight);
            if (alu_en) begin
                pulses++;
                if (exp_x.size() == 0) begin
                    chk("alu_en_extra", 1, 0);
                end else begin
                    chk("alu_drive", {alu_x, alu_y, alu_m, alu_math, alu_rs},
                        {exp_x.pop_front(), cur_y, cur_m, cur_op, cur_rs});
                end
            end
            if (res_valid) begin
                if (!inflight) begin
                    chk("res_valid_extra", 1, 0);
                end else begin
                    if (!seen_valid) chk("latency_cycle", cyc, exp_due);
                    seen_valid = 1'b1;
                    chk("res_data", res_data, exp_data);
                    chk("res_rs", res_rs, exp_rs);
                    chk("res_zero", res_zero, exp_data == 8'h00);
                    if (res_ready) begin
                        chk("pulses_left", exp_x.size(), 0);
                        inflight   = 1'b0;
                        seen_valid = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                logic [7:0] v;
                v = req_x;
                exp_x.delete();
                for (int i = 0; i <= int'(req_rep); i++) begin
                    exp_x.push_back(v);
                    v = alu_f(req_op, v, req_y);
                end
                exp_data = v;
                exp_rs   = req_rs;
                exp_due  = cyc + 1 + 2 + 2 * int'(req_rep);
                cur_y    = req_y;
                cur_m    = req_m;
                cur_op   = req_op;
                cur_rs   = req_rs;
                inflight = 1'b1;
            end
        end
    end

    // Issue one op with res_ready high and check hand-computed result, latency and pulse count.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m,
                          input math op, input logic rs, input logic [REP_W-1:0] rep,
                          input logic [7:0] want, input int want_lat, input int want_pulses);
        int acc;
        int n;
        int p0;
        p0 = pulses;
        req_x = x; req_y = y; req_m = m; req_op = op; req_rs = rs; req_rep = rep;
        req_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) chk("accept_timeout", 0, 1);
        acc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        if (!res_valid) chk("result_timeout", 0, 1);
        chk("lit_data", res_data, want);
        chk("lit_rs", res_rs, rs);
        chk("lit_zero", res_zero, want == 8'h00);
        chk("lit_latency", cyc - acc, want_lat);
        @(posedge clk); #1;
        chk("lit_pulses", pulses - p0, want_pulses);
    endtask

    initial begin
        int n;
        int p0;
        reset = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
        req_x = 8'h00; req_y = 8'h00; req_m = 8'h00; req_op = amp; req_rs = 1'b0; req_rep = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", {alu_en, res_valid, busy, res_rs, res_data, alu_x, alu_y, alu_m},
            0);
        chk("post_reset_req_ready", req_ready, 1);
        @(posedge clk); #1;

        run_op(8'h05, 8'h03, 8'hA5, add, 1'b0, 3'd0, 8'h08, 2, 1);
        chk("t1_alu_r", alu_r, 8'h08);

        run_op(8'h10, 8'h10, 8'h00, sub, 1'b1, 3'd0, 8'h00, 2, 1);
        chk("t2_alu_s", alu_s, 8'h00);
        chk("t2_alu_r_kept", alu_r, 8'h08);

        run_op(8'h80, 8'h00, 8'h00, rsc, 1'b0, 3'd3, 8'h08, 8, 4);

        run_op(8'h81, 8'h01, 8'h3C, rol, 1'b0, 3'd1, 8'h06, 4, 2);

        // Backpressure with a competing request.
        res_ready = 1'b0;
        req_x = 8'h11; req_y = 8'h22; req_m = 8'h00; req_op = add; req_rs = 1'b0; req_rep = '0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        if (!res_valid) chk("bp_timeout", 0, 1);
        @(posedge clk); #1;
        req_x = 8'h02; req_y = 8'h03; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_data", res_data, 8'h33);
            chk("bp_valid", res_valid, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", req_ready, 1);
        chk("bp_idle_busy", busy, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_taken", busy, 1);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        chk("bp_second_data", res_data, 8'h05);
        @(posedge clk); #1;

        // Reset while in SAMPLE of a repeated op.
        req_x = 8'h40; req_y = 8'h00; req_op = rsc; req_rs = 1'b0; req_rep = 3'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        p0 = pulses;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("abort_quiet", {res_valid, busy, alu_en}, 0);
        end
        @(posedge clk); #1;
        chk("abort_pulses", pulses - p0, 0);

        run_op(8'h01, 8'h01, 8'h00, add, 1'b0, 3'd0, 8'h02, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
